mc_state_sequencer: RTL and testbench

//  State register and next-state logic for the multicycle RV32I core.

---
 rtl/mc_state_sequencer.sv | 131 +++++++++++++
 tb/tb_mc_state_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_state_sequencer.sv
// Multicycle RV32I control sequencer: state register, next-state logic,
// halt/illegal detection and retired-instruction counting.
module mc_state_sequencer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             ecall_halt,
   input  logic             stall,
   output logic [3:0]       current_state,
   output logic             is_halted,
   output logic             illegal_instr,
   output logic             retire,
   output logic [CNT_W-1:0] retired_count
);

   typedef enum logic [3:0] {
      S_IF_1  = 4'd0,
      S_IF_2  = 4'd1,
      S_IF_3  = 4'd2,
      S_IF_4  = 4'd3,
      S_ID    = 4'd4,
      S_EX_1  = 4'd5,
      S_EX_2  = 4'd6,
      S_MEM_1 = 4'd7,
      S_MEM_2 = 4'd8,
      S_MEM_3 = 4'd9,
      S_MEM_4 = 4'd10,
      S_WB    = 4'd11,
      S_HALT  = 4'd12
   } state_t;

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic             r_retire;
   logic             r_illegal;
   logic [CNT_W-1:0] r_count;

   state_t w_next;
   logic   w_retire_evt;
   logic   w_illegal_evt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IF_1;
         r_retire  <= 1'b0;
         r_illegal <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state  <= w_next;
         r_retire <= w_retire_evt;
         if (w_retire_evt)  r_count   <= r_count + CNT_ONE;
         if (w_illegal_evt) r_illegal <= 1'b1;
      end
   end

   // Retire/illegal events are only raised on a taken transition, so a stall
   // simply defers them until the transition actually happens.
   always_comb begin
      w_next        = r_state;
      w_retire_evt  = 1'b0;
      w_illegal_evt = 1'b0;
      if (r_state != S_HALT && !stall) begin
         case (r_state)
            S_IF_1:  w_next = S_IF_2;
            S_IF_2:  w_next = S_IF_3;
            S_IF_3:  w_next = S_IF_4;
            S_IF_4:  w_next = S_ID;
            S_ID: begin
               case (opcode)
                  OP_ECALL: begin
                     w_next       = ecall_halt ? S_HALT : S_IF_1;
                     w_retire_evt = 1'b1;
                  end
                  OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
                  OP_BRANCH, OP_JAL, OP_JALR: w_next = S_EX_1;
                  default: begin
                     w_next        = S_IF_1;
                     w_illegal_evt = 1'b1;
                  end
               endcase
            end
            S_EX_1: begin
               case (opcode)
                  OP_BRANCH:         w_next = S_EX_2;
                  OP_LOAD, OP_STORE: w_next = S_MEM_1;
                  default:           w_next = S_WB;
               endcase
            end
            S_EX_2: begin
               w_next       = S_IF_1;
               w_retire_evt = 1'b1;
            end
            S_MEM_1: w_next = S_MEM_2;
            S_MEM_2: w_next = S_MEM_3;
            S_MEM_3: w_next = S_MEM_4;
            S_MEM_4: begin
               if (opcode == OP_LOAD) begin
                  w_next = S_WB;
               end else begin
                  w_next       = S_IF_1;
                  w_retire_evt = 1'b1;
               end
            end
            S_WB: begin
               w_next       = S_IF_1;
               w_retire_evt = 1'b1;
            end
            default: w_next = S_IF_1;
         endcase
      end
   end

   assign current_state = r_state;
   assign is_halted     = (r_state == S_HALT);
   assign illegal_instr = r_illegal;
   assign retire        = r_retire;
   assign retired_count = r_count;

endmodule

// File: tb/tb_mc_state_sequencer.sv
// Randomized scoreboard bench for mc_state_sequencer: per-instruction state
// paths come from a class table; a monitor checks every cycle and every retire.
module tb_mc_state_sequencer;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    opcode;
   logic          ecall_halt;
   logic          stall;
   logic [3:0]    current_state;
   logic          is_halted;
   logic          illegal_instr;
   logic          retire;
   logic [CW-1:0] retired_count;

   mc_state_sequencer #(.CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .ecall_halt   (ecall_halt),
      .stall        (stall),
      .current_state(current_state),
      .is_halted    (is_halted),
      .illegal_instr(illegal_instr),
      .retire       (retire),
      .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LD = 7'b0000011,
                          ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                          JALR = 7'b1100111, ECALL = 7'b1110011;

   typedef struct {
      logic [3:0]    st;
      logic          ret;
      logic [CW-1:0] cnt;
      logic          ill;
   } exp_t;

   exp_t          eq[$];
   logic [CW-1:0] rq[$];
   int            total = 0;
   int            bad   = 0;
   bit            mon_en = 0;
   int            m_cnt = 0;
   bit            m_ill = 0;

   int p[$];
   bit p_ret, p_halt, p_ill;

   task automatic chk(input string nm, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {ADD, ADDI, LD, ST, BR, JAL, JALR, ECALL};
   endfunction

   // Expected state after the coming posedge.
   task automatic push_exp(input bit rst_v, input int nst, input bit nret);
      exp_t e;
      if (!rst_v) begin
         m_cnt = 0; m_ill = 0; e.st = 4'd0; e.ret = 1'b0;
      end else begin
         e.st = 4'(nst); e.ret = nret;
         if (nret) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            rq.push_back(CW'(m_cnt));
         end
      end
      e.cnt = CW'(m_cnt);
      e.ill = m_ill;
      eq.push_back(e);
   endtask

   task automatic cyc(input bit rst_v, input bit st_v, input logic [6:0] op, input bit eh,
                      input int nst, input bit nret, input bit set_ill);
      @(posedge clk);
      #1;
      reset = rst_v; stall = st_v; opcode = op; ecall_halt = eh;
      if (set_ill && rst_v) m_ill = 1;
      push_exp(rst_v, nst, nret);
   endtask

   // Architectural path per instruction class: fetch, decode, then class tail.
   task automatic build_path(input logic [6:0] op, input bit eh);
      p = '{0, 1, 2, 3, 4};
      p_ret = 1; p_halt = 0; p_ill = 0;
      case (op)
         ADD, ADDI, JAL, JALR: p = {p, 5, 11};
         BR:    p = {p, 5, 6};
         LD:    p = {p, 5, 7, 8, 9, 10, 11};
         ST:    p = {p, 5, 7, 8, 9, 10};
         ECALL: if (eh) begin p.push_back(12); p_halt = 1; end
         default: begin p_ret = 0; p_ill = 1; end
      endcase
   endtask

   task automatic run_instr(input logic [6:0] op, input bit eh, input int stall_pct);
      int n, last, i, nxt;
      bit r;
      build_path(op, eh);
      n = p.size();
      last = p_halt ? n - 1 : n;
      i = 0;
      while (i < last) begin
         if ($urandom_range(99) < stall_pct) begin
            cyc(1, 1, op, eh, p[i], 0, 0);
         end else begin
            nxt = (i + 1 < n) ? p[i+1] : 0;
            r = p_halt ? (nxt == 12) : ((i + 1 == n) && p_ret);
            cyc(1, 0, op, eh, nxt, r, p_ill && p[i] == 4);
            i++;
         end
      end
   endtask

   always @(posedge clk) begin
      if (mon_en) begin
         #4;
         if (eq.size() == 0) begin
            chk("exp_queue_underflow", 1, 0);
         end else begin
            exp_t e;
            e = eq.pop_front();
            chk("state", current_state, e.st);
            chk("retire", retire, e.ret);
            chk("count", retired_count, e.cnt);
            chk("illegal", illegal_instr, e.ill);
            chk("halted", is_halted, (e.st == 4'd12));
            if (retire === 1'b1) begin
               if (rq.size() == 0) chk("unexpected_retire", 1, 0);
               else chk("retire_count", retired_count, rq.pop_front());
            end
         end
      end
   end

   initial begin
      static logic [6:0] ops[8] = '{ADD, ADDI, LD, ST, BR, JAL, JALR, ECALL};
      logic [6:0] op;
      int idx;
      reset = 0; stall = 0; opcode = 7'd0; ecall_halt = 0;
      mon_en = 1;
      push_exp(0, 0, 0);
      cyc(0, 0, 7'd0, 0, 0, 0, 0);

      // Directed: each class with no stalls.
      run_instr(ADD, 0, 0);
      run_instr(LD, 0, 0);
      run_instr(ST, 0, 0);
      run_instr(BR, 0, 0);
      run_instr(ECALL, 0, 0);
      run_instr(7'b1111111, 0, 0);
      run_instr(JAL, 0, 0);

      // Randomized mix with stalls; the 4-bit counter wraps several times.
      for (int k = 0; k < 60; k++) begin
         idx = $urandom_range(9);
         if (idx < 8) begin
            op = ops[idx];
            run_instr(op, (op == ECALL) ? 1'b0 : 1'($urandom_range(1)), 25);
         end else begin
            op = 7'($urandom_range(127));
            while (is_legal(op)) op = 7'($urandom_range(127));
            run_instr(op, 1'($urandom_range(1)), 25);
         end
      end

      // Stall in MEM_2, resume to MEM_3, then reset while stalled.
      begin
         static int ld_path[8] = '{0, 1, 2, 3, 4, 5, 7, 8};
         for (int k = 0; k < 7; k++) cyc(1, 0, LD, 0, ld_path[k+1], 0, 0);
         for (int k = 0; k < 3; k++) cyc(1, 1, LD, 0, 8, 0, 0);
         cyc(1, 0, LD, 0, 9, 0, 0);
         cyc(0, 1, LD, 0, 0, 0, 0);
      end
      run_instr(ADDI, 0, 20);

      // ECALL halt: absorbing for 20 cycles regardless of inputs, then reset.
      run_instr(ECALL, 1, 20);
      for (int k = 0; k < 20; k++)
         cyc(1, 1'($urandom_range(1)), 7'($urandom_range(127)), 1'($urandom_range(1)), 12, 0, 0);
      cyc(0, 0, ADD, 0, 0, 0, 0);
      run_instr(BR, 0, 20);

      @(posedge clk);
      #6;
      mon_en = 0;
      chk("exp_queue_drained", eq.size(), 0);
      chk("retire_queue_drained", rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
